// File: rtl/velocity_estimator_pkg.sv
// rtl/velocity_estimator_pkg.sv - shared state encoding and constants for the velocity estimator
package velocity_estimator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } ve_state_t;

    // Result FIFO depth and the smallest window the counter can honour.
    localparam int FIFO_DEPTH = 2;
    localparam int MIN_WINDOW = 2;

endpackage

// File: rtl/velocity_fifo.sv
// rtl/velocity_fifo.sv - 2-entry first-word-fall-through result FIFO
//
// Ports:
//   SYS_aclk, SYS_aresetn  clock, asynchronous active-low reset
//   push, push_data        write request and data (ignored when full without pop)
//   pop                    read request (ignored when empty)
//   valid, head_data       non-empty flag and the entry at the head
//   full                   both entries occupied
module velocity_fifo
    import velocity_estimator_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  SYS_aclk,
    input  logic                  SYS_aresetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full
);

    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    assign valid     = (count != 2'd0);
    assign full      = (count == 2'(FIFO_DEPTH));
    assign head_data = head;

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        tail  <= push_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Full: a push is only accepted if the head leaves this cycle.
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= push_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/velocity_estimator.sv
// rtl/velocity_estimator.sv - windowed fringe-position delta (velocity) estimator with AXIS output
//
// Ports:
//   SYS_aclk, SYS_aresetn            clock, asynchronous active-low reset
//   VE_enable                        run enable; low returns to IDLE
//   VE_window                        window length in cycles (0 and 1 act as 2)
//   VE_clear                         clears the sticky overrun flag
//   S_AXIS_tvalid/tdata/tready       position sample stream (always ready)
//   M_AXIS_tvalid/tdata/tready       signed delta result stream
//   VE_overrun                       sticky: a result was dropped on a full FIFO
module velocity_estimator
    import velocity_estimator_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int WINDOW_WIDTH     = 32
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic                        VE_enable,
    input  logic [WINDOW_WIDTH-1:0]     VE_window,
    input  logic                        VE_clear,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                        M_AXIS_tready,
    output logic                        VE_overrun
);

    ve_state_t                   state;
    ve_state_t                   state_nxt;
    logic [WINDOW_WIDTH-1:0]     win_cnt;
    logic [WINDOW_WIDTH-1:0]     win_len;
    logic [WINDOW_WIDTH-1:0]     win_eff;
    logic [AXIS_TDATA_WIDTH-1:0] ref_pos;
    logic [AXIS_TDATA_WIDTH-1:0] last_pos;
    logic [AXIS_TDATA_WIDTH-1:0] end_pos;
    logic [AXIS_TDATA_WIDTH-1:0] delta;
    logic                        terminal;
    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        drop;

    assign S_AXIS_tready = 1'b1;

    assign win_eff  = (VE_window < WINDOW_WIDTH'(MIN_WINDOW)) ? WINDOW_WIDTH'(MIN_WINDOW) : VE_window;
    assign terminal = (state == ST_RUN) && (win_cnt == win_len - WINDOW_WIDTH'(1));
    // A sample arriving in the terminal cycle belongs to the closing window.
    assign end_pos  = S_AXIS_tvalid ? S_AXIS_tdata : last_pos;
    assign delta    = end_pos - ref_pos;
    assign push     = terminal && VE_enable;
    assign pop      = M_AXIS_tvalid && M_AXIS_tready;
    assign drop     = push && fifo_full && !pop;

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!VE_enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_PRIME;
                ST_PRIME: if (S_AXIS_tvalid) state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            win_cnt  <= '0;
            win_len  <= WINDOW_WIDTH'(MIN_WINDOW);
            ref_pos  <= '0;
            last_pos <= '0;
        end else if (!VE_enable) begin
            win_cnt <= '0;
        end else if (state == ST_PRIME && S_AXIS_tvalid) begin
            ref_pos  <= S_AXIS_tdata;
            last_pos <= S_AXIS_tdata;
            win_cnt  <= '0;
            win_len  <= win_eff;
        end else if (state == ST_RUN) begin
            if (terminal) begin
                ref_pos <= end_pos;
                win_cnt <= '0;
                win_len <= win_eff;
            end else begin
                win_cnt <= win_cnt + WINDOW_WIDTH'(1);
            end
            if (S_AXIS_tvalid) begin
                last_pos <= S_AXIS_tdata;
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            VE_overrun <= 1'b0;
        end else if (drop) begin
            VE_overrun <= 1'b1;
        end else if (VE_clear) begin
            VE_overrun <= 1'b0;
        end
    end

    velocity_fifo #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH)
    ) u_fifo (
        .SYS_aclk   (SYS_aclk),
        .SYS_aresetn(SYS_aresetn),
        .push       (push),
        .push_data  (delta),
        .pop        (pop),
        .valid      (M_AXIS_tvalid),
        .head_data  (M_AXIS_tdata),
        .full       (fifo_full)
    );

endmodule

// File: tb/tb_velocity_estimator.sv
// tb/tb_velocity_estimator.sv - self-checking bench for velocity_estimator
module tb_velocity_estimator;

    localparam int DW = 32;
    localparam int WW = 32;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic          SYS_aclk = 1'b0;
    logic          SYS_aresetn = 1'b0;
    logic          VE_enable = 1'b0;
    logic [WW-1:0] VE_window = '0;
    logic          VE_clear = 1'b0;
    logic          S_AXIS_tvalid = 1'b0;
    logic [DW-1:0] S_AXIS_tdata = '0;
    logic          S_AXIS_tready;
    logic          M_AXIS_tvalid;
    logic [DW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tready = 1'b1;
    logic          VE_overrun;

    velocity_estimator #(.AXIS_TDATA_WIDTH(DW), .WINDOW_WIDTH(WW)) dut (
        .SYS_aclk     (SYS_aclk),
        .SYS_aresetn  (SYS_aresetn),
        .VE_enable    (VE_enable),
        .VE_window    (VE_window),
        .VE_clear     (VE_clear),
        .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tdata (S_AXIS_tdata),
        .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tdata (M_AXIS_tdata),
        .M_AXIS_tready(M_AXIS_tready),
        .VE_overrun   (VE_overrun)
    );

    always #5 SYS_aclk = ~SYS_aclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: windows described by the absolute edge index at which they close.
    int            m_mode;
    longint        m_cyc;
    longint        m_end;
    logic [DW-1:0] m_ref;
    logic [DW-1:0] m_last;
    logic [DW-1:0] mq[$];
    logic          m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic longint eff_window(input logic [WW-1:0] w);
        return (w < 2) ? 64'd2 : longint'(w);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cyc  = 0;
        m_end  = 0;
        m_ref  = '0;
        m_last = '0;
        mq.delete();
        m_ovr  = 1'b0;
    endtask

    task automatic model_step();
        logic          pop;
        logic          push;
        logic [DW-1:0] e;
        logic [DW-1:0] pv;
        m_cyc++;
        pop  = (mq.size() != 0) && M_AXIS_tready;
        push = 1'b0;
        pv   = '0;
        if (!VE_enable) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_PRIME;
        end else if (m_mode == M_PRIME) begin
            if (S_AXIS_tvalid) begin
                m_ref  = S_AXIS_tdata;
                m_last = S_AXIS_tdata;
                m_end  = m_cyc + eff_window(VE_window);
                m_mode = M_RUN;
            end
        end else begin
            if (m_cyc == m_end) begin
                e     = S_AXIS_tvalid ? S_AXIS_tdata : m_last;
                pv    = e - m_ref;
                push  = 1'b1;
                m_ref = e;
                m_end = m_cyc + eff_window(VE_window);
            end
            if (S_AXIS_tvalid) m_last = S_AXIS_tdata;
        end
        if (pop) void'(mq.pop_front());
        if (push && mq.size() >= 2) m_ovr = 1'b1;
        else begin
            if (push) mq.push_back(pv);
            if (VE_clear) m_ovr = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("tvalid", M_AXIS_tvalid, (mq.size() != 0));
        if (mq.size() != 0) check_eq("tdata", M_AXIS_tdata, mq[0]);
        check_eq("overrun", VE_overrun, m_ovr);
    endtask

    task automatic tick();
        @(posedge SYS_aclk);
        if (!SYS_aresetn) model_reset();
        else model_step();
        @(negedge SYS_aclk);
        compare_all();
    endtask

    initial begin
        int n;
        int first_at;
        model_reset();

        // Reset state
        repeat (3) tick();
        check_eq("rst_tdata", M_AXIS_tdata, 0);
        check_eq("rst_s_tready", S_AXIS_tready, 1);
        SYS_aresetn = 1'b1;
        tick();

        // Constant rate: +1 every 10 cycles, 100-cycle windows
        VE_window = 100;
        S_AXIS_tvalid = 1'b1;
        VE_enable = 1'b1;
        first_at = -1;
        for (int i = 0; i < 350; i++) begin
            S_AXIS_tdata = DW'(i / 10);
            tick();
            if (M_AXIS_tvalid) begin
                check_eq("const_delta", M_AXIS_tdata, 10);
                if (first_at < 0) first_at = i;
            end
        end
        check_eq("const_first", first_at, 101);
        VE_enable = 1'b0;
        repeat (2) tick();

        // Wrap and sign
        VE_window = 4;
        S_AXIS_tvalid = 1'b0;
        VE_enable = 1'b1;
        tick();
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'h7FFF_FFF0;
        tick();
        S_AXIS_tvalid = 1'b0;
        repeat (3) tick();
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'h8000_0010;
        tick();
        check_eq("wrap_valid", M_AXIS_tvalid, 1);
        check_eq("wrap_delta", M_AXIS_tdata, 32'h0000_0020);
        S_AXIS_tvalid = 1'b0;
        VE_enable = 1'b0;
        tick();
        VE_enable = 1'b1;
        tick();
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'd5;
        tick();
        S_AXIS_tvalid = 1'b0;
        repeat (3) tick();
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 32'd2;
        tick();
        check_eq("sign_delta", M_AXIS_tdata, 32'hFFFF_FFFD);
        S_AXIS_tvalid = 1'b0;
        VE_enable = 1'b0;
        repeat (2) tick();

        // Backpressure: two held, third dropped, drain in order, clear
        VE_window = 4;
        M_AXIS_tready = 1'b0;
        S_AXIS_tvalid = 1'b1;
        VE_enable = 1'b1;
        for (int i = 0; i < 22; i++) begin
            S_AXIS_tdata = $urandom;
            tick();
        end
        check_eq("bp_overrun", VE_overrun, 1);
        check_eq("bp_held", M_AXIS_tvalid, 1);
        VE_enable = 1'b0;
        M_AXIS_tready = 1'b1;
        repeat (2) tick();
        check_eq("bp_drained", M_AXIS_tvalid, 0);
        VE_clear = 1'b1;
        tick();
        VE_clear = 1'b0;
        check_eq("bp_clear", VE_overrun, 0);

        // Push+pop on full FIFO, then clear coinciding with a drop (window 0 -> 2)
        VE_window = 0;
        M_AXIS_tready = 1'b0;
        S_AXIS_tvalid = 1'b1;
        VE_enable = 1'b1;
        tick();
        tick();
        repeat (5) begin
            S_AXIS_tdata = $urandom;
            tick();
        end
        check_eq("full_before", M_AXIS_tvalid, 1);
        M_AXIS_tready = 1'b1;
        tick();
        M_AXIS_tready = 1'b0;
        check_eq("pushpop_ovr", VE_overrun, 0);
        tick();
        VE_clear = 1'b1;
        tick();
        VE_clear = 1'b0;
        check_eq("clear_vs_drop", VE_overrun, 1);
        VE_enable = 1'b0;
        M_AXIS_tready = 1'b1;
        VE_clear = 1'b1;
        repeat (3) tick();
        VE_clear = 1'b0;

        // Mid-window window change 50 -> 20
        VE_window = 50;
        VE_enable = 1'b1;
        tick();
        tick();
        n = 0;
        do begin
            if (n == 10) VE_window = 20;
            S_AXIS_tdata = $urandom;
            tick();
            n++;
        end while (!M_AXIS_tvalid && n < 200);
        check_eq("win_first", n, 50);
        n = 0;
        do begin
            tick();
            n++;
        end while (!M_AXIS_tvalid && n < 200);
        check_eq("win_second", n, 20);

        // Enable low mid-window: no result, FIFO still drains
        VE_enable = 1'b0;
        tick();
        VE_window = 3;
        VE_enable = 1'b1;
        tick();
        tick();
        M_AXIS_tready = 1'b0;
        repeat (4) tick();
        VE_enable = 1'b0;
        repeat (5) tick();
        check_eq("dis_held", M_AXIS_tvalid, 1);
        M_AXIS_tready = 1'b1;
        tick();
        check_eq("dis_drained", M_AXIS_tvalid, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            VE_enable     = ($urandom_range(0, 99) < 97);
            VE_window     = WW'($urandom_range(0, 6));
            S_AXIS_tvalid = $urandom_range(0, 1);
            S_AXIS_tdata  = $urandom;
            M_AXIS_tready = ($urandom_range(0, 3) != 0);
            VE_clear      = ($urandom_range(0, 49) == 0);
            tick();
        end
        VE_clear = 1'b0;

        // Asynchronous reset mid-RUN
        VE_window = 2;
        VE_enable = 1'b1;
        S_AXIS_tvalid = 1'b1;
        M_AXIS_tready = 1'b0;
        repeat (15) begin
            S_AXIS_tdata = $urandom;
            tick();
        end
        check_eq("pre_rst_ovr", VE_overrun, 1);
        #3 SYS_aresetn = 1'b0;
        #1;
        check_eq("arst_tvalid", M_AXIS_tvalid, 0);
        check_eq("arst_tdata", M_AXIS_tdata, 0);
        check_eq("arst_overrun", VE_overrun, 0);
        check_eq("arst_s_tready", S_AXIS_tready, 1);
        tick();
        SYS_aresetn = 1'b1;
        VE_enable = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
